// File: rtl/rom_arb_pkg.sv
// -----------------------------------------------------------------------------
// rom_arb_pkg
// Shared definitions for the program-ROM arbiter and the ROM instance.
//   port_id_e      : encoding of which requester owns a grant / pending read
//   ROM_ADDR_SIZE  : default ROM address width (shared with the ROM)
//   ROM_WORD_SIZE  : default ROM word width (shared with the ROM)
//   STARVE_W       : width of the starvation counter (covers limits 1..255)
// -----------------------------------------------------------------------------
package rom_arb_pkg;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_F    = 2'd1,
        PORT_D    = 2'd2
    } port_id_e;

    localparam int unsigned ROM_ADDR_SIZE = 11;
    localparam int unsigned ROM_WORD_SIZE = 9;
    localparam int unsigned STARVE_W      = 8;

endpackage

// File: rtl/rom_arb_pick.sv
// -----------------------------------------------------------------------------
// rom_arb_pick
// Grant decision for the two ROM requesters. Produces the id of the port that
// owns the ROM this cycle (combinational from requests and local state).
//
// Build option: define ROM_ARB_RR_EN to replace fixed priority + starvation
// guard with round-robin arbitration (StarveLimit is then unused).
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset; forces grant_o to PORT_NONE
//   f_req_i  in   fetch request
//   d_req_i  in   data-load request
//   grant_o  out  granted port id (PORT_NONE / PORT_F / PORT_D)
// -----------------------------------------------------------------------------
module rom_arb_pick
    import rom_arb_pkg::*;
#(
    parameter int unsigned StarveLimit = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     f_req_i,
    input  logic     d_req_i,
    output port_id_e grant_o
);

`ifdef ROM_ARB_RR_EN

    // Round-robin: on contention the port that did not win last time wins.
    port_id_e last_q, last_d;

    always_comb begin
        grant_o = PORT_NONE;
        last_d  = last_q;
        if (rst_n) begin
            if (f_req_i && d_req_i) begin
                grant_o = (last_q == PORT_F) ? PORT_D : PORT_F;
            end else if (f_req_i) begin
                grant_o = PORT_F;
            end else if (d_req_i) begin
                grant_o = PORT_D;
            end
        end
        // Only a real grant moves the round-robin pointer.
        if (grant_o != PORT_NONE) begin
            last_d = grant_o;
        end
    end

    // Reset to D so that F wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT_D;
        end else begin
            last_q <= last_d;
        end
    end

`else

    // Fixed priority (F first) with a starvation guard for D.
    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(StarveLimit);

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                d_forced;

    always_comb begin
        grant_o  = PORT_NONE;
        starve_d = starve_q;
        d_forced = (starve_q == LIMIT);
        if (rst_n) begin
            if (f_req_i && d_req_i) begin
                grant_o = d_forced ? PORT_D : PORT_F;
            end else if (f_req_i) begin
                grant_o = PORT_F;
            end else if (d_req_i) begin
                grant_o = PORT_D;
            end
        end
        // Count only cycles where D waits; any D grant or a withdrawn request
        // (abort) restarts the count. Saturates at the limit.
        if (!d_req_i || grant_o == PORT_D) begin
            starve_d = '0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

`endif

endmodule

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
// Shares one synchronous program ROM (1-cycle read latency) between the
// instruction-fetch port (f_*) and the data/constant-load port (d_*).
// At most one request is granted per cycle; the returned word is steered to
// the port granted in the previous cycle, and each port's rdata holds its last
// word until that port's next response.
//
// Build option: ROM_ARB_RR_EN selects round-robin arbitration instead of fixed
// priority with a starvation guard (see rom_arb_pick).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   f_req/f_addr         fetch request and address (held until f_gnt)
//   f_gnt                combinational fetch accept
//   f_rvalid/f_rdata     fetch response (cycle after f_gnt) / held data
//   d_req/d_addr         data-load request and address
//   d_gnt                combinational data-load accept
//   d_rvalid/d_rdata     data-load response / held data
//   rom_addr/rom_en      ROM drive
//   rom_do               ROM read data, valid the cycle after rom_en
// -----------------------------------------------------------------------------
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned AddrSize    = ROM_ADDR_SIZE,
    parameter int unsigned WordSize    = ROM_WORD_SIZE,
    parameter int unsigned StarveLimit = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                f_req,
    input  logic [AddrSize-1:0] f_addr,
    output logic                f_gnt,
    output logic                f_rvalid,
    output logic [WordSize-1:0] f_rdata,
    input  logic                d_req,
    input  logic [AddrSize-1:0] d_addr,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [WordSize-1:0] d_rdata,
    output logic [AddrSize-1:0] rom_addr,
    output logic                rom_en,
    input  logic [WordSize-1:0] rom_do
);

    port_id_e            grant;
    port_id_e            pending_q, pending_d;
    logic [WordSize-1:0] f_hold_q, f_hold_d;
    logic [WordSize-1:0] d_hold_q, d_hold_d;

    rom_arb_pick #(
        .StarveLimit (StarveLimit)
    ) u_pick (
        .clk     (clk),
        .rst_n   (rst_n),
        .f_req_i (f_req),
        .d_req_i (d_req),
        .grant_o (grant)
    );

    // ROM drive follows the grant directly so the read starts this cycle.
    always_comb begin
        f_gnt    = (grant == PORT_F);
        d_gnt    = (grant == PORT_D);
        rom_en   = f_gnt | d_gnt;
        rom_addr = '0;
        if (f_gnt) begin
            rom_addr = f_addr;
        end else if (d_gnt) begin
            rom_addr = d_addr;
        end
    end

    // The pending register remembers who owns the word arriving next cycle;
    // rom_do is only forwarded when it matches such a grant.
    always_comb begin
        pending_d = grant;
        f_rvalid  = (pending_q == PORT_F);
        d_rvalid  = (pending_q == PORT_D);
        f_hold_d  = f_rvalid ? rom_do : f_hold_q;
        d_hold_d  = d_rvalid ? rom_do : d_hold_q;
        // Present the fresh word in the response cycle, the held word after.
        f_rdata   = f_hold_d;
        d_rdata   = d_hold_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= PORT_NONE;
            f_hold_q  <= '0;
            d_hold_q  <= '0;
        end else begin
            pending_q <= pending_d;
            f_hold_q  <= f_hold_d;
            d_hold_q  <= d_hold_d;
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
module tb_rom_arbiter;
    localparam int AW = 11;
    localparam int WW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          f_req = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic          f_gnt;
    logic          f_rvalid;
    logic [WW-1:0] f_rdata;
    logic          d_req = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic          d_gnt;
    logic          d_rvalid;
    logic [WW-1:0] d_rdata;
    logic [AW-1:0] rom_addr;
    logic          rom_en;
    logic [WW-1:0] rom_do = '0;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic          f;
        logic          d;
        logic [AW-1:0] addr;
    } resp_t;

    typedef struct packed {
        logic          fr;
        logic [AW-1:0] fa;
        logic          dr;
        logic [AW-1:0] da;
        logic          ef;
        logic          ed;
    } vec_t;

    resp_t         q[$];
    logic [WW-1:0] f_hold = '0;
    logic [WW-1:0] d_hold = '0;

    rom_arbiter #(
        .AddrSize    (AW),
        .WordSize    (WW),
        .StarveLimit (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rvalid (f_rvalid),
        .f_rdata  (f_rdata),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .rom_addr (rom_addr),
        .rom_en   (rom_en),
        .rom_do   (rom_do)
    );

    always #5 clk = ~clk;

    // ROM contents as a pure function of the address.
    function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
        logic [19:0] t;
        t = 20'(a) * 20'd37 + 20'd11;
        return t[8:0] ^ {1'b0, a[10:3]};
    endfunction

    // Synchronous ROM model: zeros when not enabled.
    always @(posedge clk) begin
        rom_do <= rom_en ? mem_word(rom_addr) : '0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the registered response produced by the previous cycle.
    task automatic check_resp();
        resp_t e;
        if (q.size() == 0) return;
        e = q.pop_front();
        chk("f_rvalid", 32'(f_rvalid), 32'(e.f));
        chk("d_rvalid", 32'(d_rvalid), 32'(e.d));
        if (e.f) f_hold = mem_word(e.addr);
        if (e.d) d_hold = mem_word(e.addr);
        chk("f_rdata", 32'(f_rdata), 32'(f_hold));
        chk("d_rdata", 32'(d_rdata), 32'(d_hold));
    endtask

    // One cycle: called at a falling edge, returns at the next falling edge.
    task automatic step(input logic fr, input logic [AW-1:0] fa,
                        input logic dr, input logic [AW-1:0] da,
                        input logic ef, input logic ed, input string tag);
        resp_t e;
        logic [AW-1:0] ea;
        check_resp();
        f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
        #1;
        ea = ef ? fa : (ed ? da : '0);
        chk("f_gnt", 32'(f_gnt), 32'(ef));
        chk("d_gnt", 32'(d_gnt), 32'(ed));
        chk("rom_en", 32'(rom_en), 32'(ef | ed));
        chk("rom_addr", 32'(rom_addr), 32'(ea));
        e.f = ef; e.d = ed; e.addr = ea;
        q.push_back(e);
        $display("%s: f_req=%0b f_addr=%03h d_req=%0b d_addr=%03h exp_gnt f=%0b d=%0b",
                 tag, fr, fa, dr, da, ef, ed);
        @(negedge clk);
    endtask

    // One-cycle reset with both requests high to confirm grants are gated.
    task automatic do_reset(input string tag);
        resp_t e;
        rst_n = 1'b0;
        f_req = 1'b1; f_addr = 11'h005; d_req = 1'b1; d_addr = 11'h001;
        #1;
        chk("rst_f_gnt", 32'(f_gnt), 32'd0);
        chk("rst_d_gnt", 32'(d_gnt), 32'd0);
        chk("rst_rom_en", 32'(rom_en), 32'd0);
        chk("rst_f_rvalid", 32'(f_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst_f_rdata", 32'(f_rdata), 32'd0);
        chk("rst_d_rdata", 32'(d_rdata), 32'd0);
        q.delete();
        f_hold = '0;
        d_hold = '0;
        $display("%s: reset pulse", tag);
        @(negedge clk);
        f_req = 1'b0; d_req = 1'b0;
        rst_n = 1'b1;
        e.f = 1'b0; e.d = 1'b0; e.addr = '0;
        q.push_back(e);
        @(negedge clk);
    endtask

    vec_t tbl[12];
    logic [9:0] cont_d;
    logic [7:0] abort_d;

    initial begin
        // Non-contended traffic: identical expectations in both modes.
        tbl[0]  = '{1'b1, 11'h000, 1'b0, 11'h000, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 11'h001, 1'b0, 11'h000, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 11'h002, 1'b0, 11'h000, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 11'h000, 1'b1, 11'h010, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 11'h020, 1'b0, 11'h000, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 11'h021, 1'b0, 11'h000, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 11'h7FF, 1'b0, 11'h000, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 11'h000, 1'b1, 11'h7FF, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 11'h000, 1'b1, 11'h3AB, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 11'h004, 1'b0, 11'h155, 1'b1, 1'b0};

`ifdef ROM_ARB_RR_EN
        cont_d  = 10'b10_1010_1010;  // F,D,F,D,... from reset
        abort_d = 8'b1010_1010;      // F,D,F(only),D,F,D,F,D
`else
        cont_d  = 10'b10_0001_0000;  // D forced on 5th and 10th cycle
        abort_d = 8'b1000_0000;      // counter back to 0 after abort
`endif

        @(negedge clk);
        do_reset("init");

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].fr, tbl[i].fa, tbl[i].dr, tbl[i].da,
                 tbl[i].ef, tbl[i].ed, $sformatf("vec%0d", i));
        end
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, "drain");

        // Continuous contention from a fresh reset.
        do_reset("pre_contention");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 11'(11'h040 + i), 1'b1, 11'h100,
                 !cont_d[i], cont_d[i], $sformatf("cont%0d", i));
        end

        // D waits two cycles then withdraws; then sustained contention again.
        for (int i = 0; i < 8; i++) begin
            logic dr;
            dr = (i != 2);
            step(1'b1, 11'(11'h060 + i), dr, 11'h120,
                 !abort_d[i], abort_d[i], $sformatf("abort%0d", i));
        end
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, "drain");

        // Reset while a fetch response is outstanding.
        step(1'b1, 11'h005, 1'b0, '0, 1'b1, 1'b0, "pre_rst_fetch");
        do_reset("mid_read");
        step(1'b1, 11'h006, 1'b0, '0, 1'b1, 1'b0, "post_rst_fetch");
        step(1'b0, '0, 1'b1, 11'h011, 1'b0, 1'b1, "post_rst_data");
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, "drain");
        check_resp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single synchronous program ROM between two requesters: the instruction-fetch port (f_*) and the data/constant-load port (d_*).
- Each cycle it grants at most one request and drives the ROM address and enable.
- It tracks the ROM's one-cycle read latency and steers the returned word to the granted port.
- Sits between the CPU core and the ROM instance.

Parameters:
- AddrSize, 11, ROM address width in bits.
- WordSize, 9, ROM word width in bits.
- StarveLimit, 4, consecutive denied cycles after which a waiting d_req is forced through (fixed-priority mode only). Legal range 1..255.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch request; held high with f_addr stable until f_gnt.
- f_addr  in  AddrSize  fetch address.
- f_gnt  out  1  combinational; fetch request accepted this cycle.
- f_rvalid  out  1  registered; fetch data valid this cycle.
- f_rdata  out  WordSize  fetch data.
- d_req  in  1  data-load request; same rules as f_req.
- d_addr  in  AddrSize  data-load address.
- d_gnt  out  1  combinational; data request accepted this cycle.
- d_rvalid  out  1  registered; data-load data valid this cycle.
- d_rdata  out  WordSize  data-load data.
- rom_addr  out  AddrSize  to ROM addr.
- rom_en  out  1  to ROM enable.
- rom_do  in  WordSize  from ROM data out; valid the cycle after rom_en.

Behaviour:
- Reset values:
  - Outputs: f_rvalid = 0, d_rvalid = 0, f_rdata = 0, d_rdata = 0.
  - Internal: starve counter = 0, pending-port register = none, last-grant = D.
  - During reset f_gnt = d_gnt = 0 and rom_en = 0.
- Grant is combinational from req and state. At most one of f_gnt/d_gnt is high.
  - rom_en = f_gnt | d_gnt.
  - rom_addr = address of the granted port, or 0 when idle.
- Latency: a grant in cycle N produces rvalid = 1 on that port in cycle N+1.
  - x_rdata = rom_do in that cycle.
  - One request per cycle is sustained back-to-back; there is no bubble.
- x_rdata holds the last word returned to that port until its next rvalid. The other port's data never disturbs it.
- Fixed-priority mode (default):
  - f_req wins when both ports request.
  - Starve counter increments on each cycle with d_req = 1 and d_gnt = 0. It saturates at StarveLimit.
  - When the counter equals StarveLimit and d_req = 1, d wins over f that cycle.
  - Counter clears on d_gnt or when d_req = 0.
- Only one request: it is granted in the same cycle regardless of mode.
- No request: rom_en = 0 and both rvalid are 0 the next cycle.
- A requester that drops req before gnt aborts cleanly; no response is produced.
- Reset mid-operation: an outstanding response is discarded. rvalid is 0 in the cycle after rst_n deasserts, even if a grant occurred the cycle before reset.
- The ROM returns zeros when not enabled; the arbiter never forwards rom_do without a matching pending grant.

Optional Feature:
- Macro: ROM_ARB_RR_EN.
- Defined:
  - Fixed priority and the starve counter are removed.
  - Contention is resolved round-robin: the port not granted last wins.
  - last-grant updates only on an actual grant.
  - After reset last-grant = D, so F wins the first contention.
  - StarveLimit is ignored.
- Undefined: fixed-priority with the starvation guard, as described under Behaviour.

Decomposition:
- Shared package rom_arb_pkg holds:
  - port-id encoding (PORT_NONE = 2'd0, PORT_F = 2'd1, PORT_D = 2'd2);
  - default AddrSize and WordSize constants shared with the ROM.
- One natural sub-module: rom_arb_pick.
  - Contains the grant decision (priority or round-robin logic plus starve counter).
  - Emits the grant id. The top handles the pending register, ROM drive and data steering.

Test Plan:
- Fetch only: f_req = 1 with f_addr = 0x000, 0x001, 0x002 on consecutive cycles -> f_gnt = 1 each cycle; f_rvalid in the following cycles with f_rdata = Mem[0..2]; d_rvalid = 0 throughout.
- Contention, fixed mode, StarveLimit = 4: f_req and d_req high continuously, d_addr = 0x100 -> f granted 4 cycles; d_gnt in the 5th; d_rvalid the next cycle with d_rdata = Mem[0x100]; counter restarts.
- Round-robin (ROM_ARB_RR_EN): both ports requesting continuously -> grants alternate F, D, F, D starting with F after reset.
- Data hold: d granted once at 0x010, then f traffic only -> d_rdata stays at Mem[0x010] while f_rdata updates.
- Reset mid-read: f granted at 0x005, rst_n low for 1 cycle in the next cycle -> f_rvalid stays 0; all outputs 0; the first post-reset grant behaves normally.
- Abort: d_req high 2 cycles under f contention, then dropped before grant -> no d_rvalid; starve counter returns to 0.
